// File: rtl/switch_pio_debounce_if.sv
// rtl/switch_pio_debounce_if.sv - Avalon-MM register bus and interrupt bundle for switch_pio_debounce
interface switch_pio_debounce_if #(
  parameter int WIDTH = 10
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;
  logic             irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/switch_pio_debounce.sv
// rtl/switch_pio_debounce.sv - synchronised, debounced switch input port with sticky edge capture and maskable irq
module switch_pio_debounce #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  switch_pio_debounce_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_pipe [SYNC_STAGES];
  logic [CW-1:0]    cnt       [WIDTH];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rdata;
  logic             wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= '0;
    end else begin
      sync_pipe[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
    end
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

  // A bit only follows sync after DEBOUNCE_CYCLES consecutive differing samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;
  assign ev   = (EDGE_TYPE == 0) ? rise :
                (EDGE_TYPE == 1) ? fall : (rise | fall);

  assign wr  = bus.chipselect & ~bus.write_n;
  assign clr = (wr && (bus.address == 2'd3)) ? bus.writedata : '0;

  always_comb begin
    rdata = '0;
    case (bus.address)
      2'd0:    rdata = deb;
      2'd1:    rdata = sync;
      2'd2:    rdata = mask;
      default: rdata = capture;
    endcase
  end

  // Set beats clear so an edge landing on the acknowledge write is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d        <= '0;
      mask         <= '0;
      capture      <= '0;
      bus.readdata <= '0;
    end else begin
      deb_d        <= deb;
      capture      <= ev | (capture & ~clr);
      bus.readdata <= rdata;
      if (wr && (bus.address == 2'd2)) mask <= bus.writedata;
    end
  end

  assign bus.irq = |(capture & mask);

endmodule
